// File: rtl/alu_console.sv
// ALU bench console: debounced button control, 8-op ALU with registered result/flags,
// accumulate chaining and a display-mode mux for the 7-segment data word.
module alu_console #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DB_CYCLES = 20,
  parameter int unsigned DB_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic [5:0]       swb,
  output logic [WIDTH-1:0] disp_data,
  output logic [4:0]       flags,
  output logic             res_valid,
  output logic [1:0]       mode
);

  localparam int unsigned NB   = 6;
  localparam int unsigned SH_W = $clog2(WIDTH);
  localparam int unsigned B_ACC  = 0;
  localparam int unsigned B_MODE = 1;
  localparam int unsigned B_EXEC = 2;
  localparam int unsigned B_LDOP = 3;
  localparam int unsigned B_LDB  = 4;
  localparam int unsigned B_LDA  = 5;
  localparam logic [1:0] M_SW = 2'd0;
  localparam logic [1:0] M_A  = 2'd1;
  localparam logic [1:0] M_B  = 2'd2;
  localparam logic [1:0] M_F  = 2'd3;

  logic [NB-1:0]            s1_q, s2_q, db_q, db_d, pulse_q, pulse_d;
  logic [NB-1:0][DB_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]         a_q, a_d, b_q, b_d, f_q, f_d, alu_f;
  logic [2:0]               op_q, op_d;
  logic [4:0]               flags_q, flags_d, alu_flags;
  logic                     valid_q, valid_d;
  logic [1:0]               mode_q, mode_d;
  logic [WIDTH:0]           add_w, sub_w;
  logic                     alu_cf, alu_of;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
      pulse_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      op_q    <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
      mode_q  <= M_SW;
    end else begin
      s1_q    <= swb;
      s2_q    <= s1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      op_q    <= op_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
    end
  end

  // Level flips after DB_CYCLES consecutive synced samples that disagree with it.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NB; i++) begin
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
          db_d[i]  = s2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
    pulse_d = db_d & ~db_q;
  end

  always_comb begin
    add_w  = {1'b0, a_q} + {1'b0, b_q};
    sub_w  = {1'b0, a_q} - {1'b0, b_q};
    alu_f  = '0;
    alu_cf = 1'b0;
    alu_of = 1'b0;
    case (op_q)
      3'd0: alu_f = a_q & b_q;
      3'd1: alu_f = a_q | b_q;
      3'd2: alu_f = a_q ^ b_q;
      3'd3: alu_f = ~(a_q | b_q);
      3'd4: begin
        alu_f  = add_w[WIDTH-1:0];
        alu_cf = add_w[WIDTH];
        alu_of = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_f[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'd5: begin
        alu_f  = sub_w[WIDTH-1:0];
        alu_cf = sub_w[WIDTH];
        alu_of = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_f[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'd6: alu_f = WIDTH'($signed(a_q) < $signed(b_q));
      default: alu_f = a_q << b_q[SH_W-1:0];
    endcase
    alu_flags = {~^alu_f, alu_cf, alu_f[WIDTH-1], alu_of, (alu_f == '0)};
  end

  // One action per cycle; lower-priority pulses in the same cycle are dropped.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    op_d    = op_q;
    flags_d = flags_q;
    valid_d = valid_q;
    mode_d  = mode_q;
    if (pulse_q[B_LDA]) begin
      a_d    = sw;
      mode_d = M_A;
    end else if (pulse_q[B_LDB]) begin
      b_d    = sw;
      mode_d = M_B;
    end else if (pulse_q[B_LDOP]) begin
      op_d   = sw[2:0];
      mode_d = M_SW;
    end else if (pulse_q[B_EXEC]) begin
      f_d     = alu_f;
      flags_d = alu_flags;
      valid_d = 1'b1;
      mode_d  = M_F;
    end else if (pulse_q[B_ACC]) begin
      if (valid_q) begin
        a_d    = f_q;
        mode_d = M_A;
      end
    end else if (pulse_q[B_MODE]) begin
      mode_d = mode_q + 2'd1;
    end
  end

  always_comb begin
    case (mode_q)
      M_A:     disp_data = a_q;
      M_B:     disp_data = b_q;
      M_F:     disp_data = f_q;
      default: disp_data = sw;
    endcase
  end

  assign flags     = flags_q;
  assign res_valid = valid_q;
  assign mode      = mode_q;

endmodule
